// File: rtl/ascii_to_mod26_if.sv
// rtl/ascii_to_mod26_if.sv - key character in / shift amounts out bundle for ascii_to_mod26
interface ascii_to_mod26_if;
   logic       in_valid;
   logic [7:0] ascii_in;
   logic       out_valid;
   logic [7:0] mod26_out;
   logic [7:0] mod26_inv;
   logic       is_letter;

   modport master (
      output in_valid, ascii_in,
      input  out_valid, mod26_out, mod26_inv, is_letter
   );

   modport slave (
      input  in_valid, ascii_in,
      output out_valid, mod26_out, mod26_inv, is_letter
   );
endinterface

// File: rtl/ascii_to_mod26.sv
// rtl/ascii_to_mod26.sv - ASCII key character to Caesar encrypt/decrypt shift, registered
// Define ASCII_TO_MOD26_UPPER_EN to also accept uppercase 'A'..'Z'.
module ascii_to_mod26 (
   input logic             keyboard_clk,
   input logic             reset,
   ascii_to_mod26_if.slave bus
);

   logic [7:0] shift_next;
   logic [7:0] inv_next;
   logic       letter_next;

   // Subtraction only happens inside a matched range, so nothing can wrap.
   always_comb begin
      shift_next  = 8'd0;
      letter_next = 1'b0;
      if (bus.ascii_in >= 8'h61 && bus.ascii_in <= 8'h7A) begin
         shift_next  = bus.ascii_in - 8'h61;
         letter_next = 1'b1;
      end
`ifdef ASCII_TO_MOD26_UPPER_EN
      else if (bus.ascii_in >= 8'h41 && bus.ascii_in <= 8'h5A) begin
         shift_next  = bus.ascii_in - 8'h41;
         letter_next = 1'b1;
      end
`else
      else begin
         shift_next  = 8'd0;
         letter_next = 1'b0;
      end
`endif
   end

   always_comb begin
      inv_next = 8'd0;
      if (shift_next != 8'd0)
         inv_next = 8'd26 - shift_next;
   end

   always_ff @(posedge keyboard_clk) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.mod26_out <= 8'd0;
         bus.mod26_inv <= 8'd0;
         bus.is_letter <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.mod26_out <= shift_next;
            bus.mod26_inv <= inv_next;
            bus.is_letter <= letter_next;
         end
      end
   end

endmodule

// File: tb/tb_ascii_to_mod26.sv
// tb/tb_ascii_to_mod26.sv - randomized and directed self-checking bench for ascii_to_mod26
module tb_ascii_to_mod26;

   logic keyboard_clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   ascii_to_mod26_if bus ();

   ascii_to_mod26 dut (
      .keyboard_clk (keyboard_clk),
      .reset        (reset),
      .bus          (bus.slave)
   );

   always #5 keyboard_clk = ~keyboard_clk;

   int exp_valid  = 0;
   int exp_shift  = 0;
   int exp_inv    = 0;
   int exp_letter = 0;

   task automatic check(input string tag, input int observed, input int expected);
      tests++;
      if (observed !== expected) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Reference: letter position in the alphabet, decrypt is the additive inverse mod 26.
   function automatic int ref_letter(input int c);
      if (c >= "a" && c <= "z") return 1;
`ifdef ASCII_TO_MOD26_UPPER_EN
      if (c >= "A" && c <= "Z") return 1;
`endif
      return 0;
   endfunction

   function automatic int ref_shift(input int c);
      if (ref_letter(c) == 0) return 0;
      return (c >= "a") ? c - "a" : c - "A";
   endfunction

   task automatic cycle(input logic r, input logic v, input logic [7:0] a);
      reset        = r;
      bus.in_valid = v;
      bus.ascii_in = a;
      @(posedge keyboard_clk);
      #1;
      if (r) begin
         exp_valid = 0; exp_shift = 0; exp_inv = 0; exp_letter = 0;
      end else begin
         exp_valid = int'(v);
         if (v) begin
            exp_shift  = ref_shift(int'(a));
            exp_inv    = (26 - exp_shift) % 26;
            exp_letter = ref_letter(int'(a));
         end
      end
      check("out_valid", int'(bus.out_valid), exp_valid);
      check("mod26_out", int'(bus.mod26_out), exp_shift);
      check("mod26_inv", int'(bus.mod26_inv), exp_inv);
      check("is_letter", int'(bus.is_letter), exp_letter);
   endtask

   initial begin
      logic [7:0] a;
      bus.in_valid = 1'b1;
      bus.ascii_in = 8'h64;

      cycle(1'b1, 1'b1, 8'h64);
      cycle(1'b1, 1'b1, 8'h64);
      cycle(1'b0, 1'b1, 8'h64);
      check("first_after_reset_shift", int'(bus.mod26_out), 3);
      check("first_after_reset_inv", int'(bus.mod26_inv), 23);

      cycle(1'b0, 1'b1, 8'h61);
      cycle(1'b0, 1'b1, 8'h7A);
      check("z_shift", int'(bus.mod26_out), 25);
      check("z_inv", int'(bus.mod26_inv), 1);
      cycle(1'b0, 1'b1, 8'h60);
      cycle(1'b0, 1'b1, 8'h7B);
      cycle(1'b0, 1'b1, 8'h41);
      cycle(1'b0, 1'b1, 8'h5A);
      cycle(1'b0, 1'b1, 8'h40);
      cycle(1'b0, 1'b1, 8'h5B);
      check("bound_5b_letter", int'(bus.is_letter), 0);
      cycle(1'b0, 1'b1, 8'hE1);
      check("high_byte_letter", int'(bus.is_letter), 0);

      cycle(1'b0, 1'b1, 8'h6D);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
      check("hold_shift", int'(bus.mod26_out), 12);
      check("hold_inv", int'(bus.mod26_inv), 14);

      cycle(1'b0, 1'b1, 8'h62);
      cycle(1'b0, 1'b1, 8'h63);
      cycle(1'b1, 1'b1, 8'h64);
      cycle(1'b0, 1'b1, 8'h65);
      check("after_mid_reset_shift", int'(bus.mod26_out), 4);
      check("after_mid_reset_inv", int'(bus.mod26_inv), 22);

      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0: a = 8'($urandom_range(0, 255));
            1: a = 8'($urandom_range(8'h61, 8'h7A));
            2: a = 8'($urandom_range(8'h41, 8'h5A));
            default: a = 8'($urandom_range(8'h3F, 8'h7C));
         endcase
         cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, a);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
